// File: rtl/program_loader.sv
// Byte-stream program loader: assembles 16-bit words (high byte first) and writes them to
// program memory from address 0. Optional checksum byte check enabled by LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_ADDR        = 11,
    parameter int NB_OPCODE      = 5,
    parameter int NB_BYTE        = 8,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 5'b00000
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NB_BYTE-1:0]        i_rx_data,
    input  logic                      i_rx_valid,
    input  logic                      i_restart,
    output logic                      o_wr_enb_rom,
    output logic [NB_ADDR-1:0]        o_wr_addr,
    output logic [NB_INSTRUCTION-1:0] o_wr_data,
    output logic                      o_cpu_reset,
    output logic                      o_done,
    output logic [NB_ADDR:0]          o_word_count,
    output logic                      o_error
);

    localparam logic [2:0] WAIT_HI = 3'd0;
    localparam logic [2:0] WAIT_LO = 3'd1;
    localparam logic [2:0] WRITE   = 3'd2;
    localparam logic [2:0] DONE    = 3'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] CHECK   = 3'd4;
`endif

    localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;
    localparam logic [NB_ADDR-1:0] ADDR_STEP = 1;
    localparam logic [NB_ADDR:0]   WORD_STEP = 1;

    logic [2:0]         state;
    logic [NB_BYTE-1:0] hi;
    logic [NB_ADDR-1:0] addr;
    logic               last_word;

    // The word being written this cycle sits in o_wr_data, so it decides termination.
    assign last_word = (o_wr_data[NB_INSTRUCTION-1 -: NB_OPCODE] == HALT_OPCODE)
                    || (addr == LAST_ADDR);

`ifdef LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0] checksum;
    logic               accept;

    assign accept = i_rx_valid && ((state == WAIT_HI) || (state == WAIT_LO)
                                || ((state == WRITE) && !last_word));

    always_ff @(posedge i_clock) begin
        if (i_reset || i_restart) begin
            checksum <= '0;
            o_error  <= 1'b0;
        end else begin
            if (accept)
                checksum <= checksum ^ i_rx_data;
            if ((state == CHECK) && i_rx_valid && (i_rx_data != checksum))
                o_error <= 1'b1;
        end
    end
`else
    assign o_error = 1'b0;
`endif

    // NOTE: all state below is sequential, so every assignment is non-blocking; the
    // default write-enable clear at the top makes the enable a single-cycle pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= WAIT_HI;
            hi           <= '0;
            addr         <= '0;
            o_wr_enb_rom <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_cpu_reset  <= 1'b1;
            o_done       <= 1'b0;
            o_word_count <= '0;
        end else begin
            o_wr_enb_rom <= 1'b0;
            if (i_restart) begin
                state        <= WAIT_HI;
                addr         <= '0;
                o_word_count <= '0;
                o_cpu_reset  <= 1'b1;
                o_done       <= 1'b0;
            end else begin
                case (state)
                    WAIT_HI: begin
                        if (i_rx_valid) begin
                            hi    <= i_rx_data;
                            state <= WAIT_LO;
                        end
                    end
                    WAIT_LO: begin
                        if (i_rx_valid) begin
                            o_wr_enb_rom <= 1'b1;
                            o_wr_addr    <= addr;
                            o_wr_data    <= {hi, i_rx_data};
                            state        <= WRITE;
                        end
                    end
                    WRITE: begin
                        o_word_count <= o_word_count + WORD_STEP;
                        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                            state       <= CHECK;
`else
                            state       <= DONE;
                            o_done      <= 1'b1;
                            o_cpu_reset <= 1'b0;
`endif
                        end else begin
                            addr <= addr + ADDR_STEP;
                            // A byte arriving here already belongs to the next word.
                            if (i_rx_valid) begin
                                hi    <= i_rx_data;
                                state <= WAIT_LO;
                            end else begin
                                state <= WAIT_HI;
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CHECK: begin
                        if (i_rx_valid) begin
                            state       <= DONE;
                            o_done      <= 1'b1;
                            o_cpu_reset <= (i_rx_data != checksum);
                        end
                    end
`endif
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= WAIT_HI;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a word-level model predicts every memory write,
// and directed loads pin timing, termination, restart and reset behaviour.
module tb_program_loader;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        i_restart;
    logic        o_wr_enb_rom;
    logic [10:0] o_wr_addr;
    logic [15:0] o_wr_data;
    logic        o_cpu_reset;
    logic        o_done;
    logic [11:0] o_word_count;
    logic        o_error;

    program_loader dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .i_restart    (i_restart),
        .o_wr_enb_rom (o_wr_enb_rom),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_cpu_reset  (o_cpu_reset),
        .o_done       (o_done),
        .o_word_count (o_word_count),
        .o_error      (o_error)
    );

    always #5 i_clock = ~i_clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;

    always @(posedge i_clock) cycle++;

    task automatic check(input string name, input longint actual, input longint expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Model: pair bytes high-first into words, one write per word from address 0,
    // stopping after a HALT opcode or after the last address.
    logic [7:0]  stim[$];
    logic [10:0] exp_addr[$];
    logic [15:0] exp_data[$];
    logic [7:0]  exp_xor;
    int          exp_words;

    function automatic void plan_load();
        int a;
        logic [15:0] w;
        a = 0;
        exp_xor = 8'h00;
        exp_words = 0;
        for (int i = 0; i + 1 < stim.size(); i += 2) begin
            w = {stim[i], stim[i+1]};
            exp_addr.push_back(a[10:0]);
            exp_data.push_back(w);
            exp_words++;
            exp_xor = exp_xor ^ stim[i] ^ stim[i+1];
            if (w[15:11] == 5'b00000 || a == 2047) break;
            a++;
        end
    endfunction

    function automatic void add_word(input logic [7:0] h, input logic [7:0] l);
        stim.push_back(h);
        stim.push_back(l);
    endfunction

    logic        checking = 1'b0;
    logic        prev_enb = 1'b0;
    int          writes_seen = 0;
    logic [10:0] cap_addr[$];
    logic [15:0] cap_data[$];
    int          cap_cycle[$];

    function automatic void clear_model();
        stim.delete();
        exp_addr.delete();
        exp_data.delete();
        cap_addr.delete();
        cap_data.delete();
        cap_cycle.delete();
        writes_seen = 0;
    endfunction

    // Compare process: every write against the model, plus per-cycle output rules.
    always @(posedge i_clock) begin
        #2;
        if (checking) begin
            if (o_wr_enb_rom) begin
                writes_seen++;
                check("wr_single_cycle", prev_enb, 0);
                cap_addr.push_back(o_wr_addr);
                cap_data.push_back(o_wr_data);
                cap_cycle.push_back(cycle);
                if (exp_addr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                             o_wr_addr, o_wr_data);
                end else begin
                    check("wr_addr", o_wr_addr, exp_addr.pop_front());
                    check("wr_data", o_wr_data, exp_data.pop_front());
                end
            end
            check("word_count", o_word_count, writes_seen - (o_wr_enb_rom ? 1 : 0));
            check("cpu_reset_rule", o_cpu_reset, !(o_done && !o_error));
            prev_enb = o_wr_enb_rom;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(negedge i_clock);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_stim();
        foreach (stim[i]) send_byte(stim[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
        idle(2);
        send_byte(exp_xor);
`else
        idle(1);
`endif
    endtask

    task automatic start_load();
        i_restart = 1'b1;
        clear_model();
        @(negedge i_clock);
        i_restart = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int done_cycle);
        int n;
        n = 0;
        while (!o_done && n < budget) begin
            @(negedge i_clock);
            n++;
        end
        done_cycle = cycle;
        check("done_reached", o_done, 1);
        check("pending_writes", exp_addr.size(), 0);
    endtask

    task automatic check_cap(input string name, input int idx,
                             input logic [10:0] a, input logic [15:0] d);
        if (idx >= cap_addr.size()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: write %0d missing, only %0d seen", name, idx, cap_addr.size());
        end else begin
            check({name, "_addr"}, cap_addr[idx], a);
            check({name, "_data"}, cap_data[idx], d);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_enb"},  o_wr_enb_rom, 0);
        check({tag, "_wr_addr"}, o_wr_addr, 0);
        check({tag, "_wr_data"}, o_wr_data, 0);
        check({tag, "_cpu_rst"}, o_cpu_reset, 1);
        check({tag, "_done"},    o_done, 0);
        check({tag, "_count"},   o_word_count, 0);
        check({tag, "_error"},   o_error, 0);
    endtask

    initial begin
        int dc;
        i_reset    = 1'b1;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        i_restart  = 1'b0;
        clear_model();
        repeat (3) @(negedge i_clock);
        check_reset_values("rst");
        i_reset  = 1'b0;
        checking = 1'b1;

        // Three-word program ending in HALT.
        add_word(8'h08, 8'h05);
        add_word(8'h10, 8'h03);
        add_word(8'h00, 8'h00);
        plan_load();
        send_stim();
        finish_load();
        wait_done(20, dc);
        check_cap("t1_w0", 0, 11'h000, 16'h0805);
        check_cap("t1_w1", 1, 11'h001, 16'h1003);
        check_cap("t1_w2", 2, 11'h002, 16'h0000);
        check("t1_count", o_word_count, 3);
        check("t1_cpu_released", o_cpu_reset, 0);
        check("t1_error", o_error, 0);
`ifndef LOADER_CHECKSUM_EN
        if (cap_cycle.size() == 3) check("t1_done_latency", dc - cap_cycle[2], 1);
`endif

        // Write latency and a high byte strobed during the WRITE cycle.
        start_load();
        add_word(8'h11, 8'h22);
        add_word(8'h08, 8'h09);
        add_word(8'h00, 8'h00);
        plan_load();
        send_byte(8'h11);
        idle(2);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h22;
        @(negedge i_clock);
        check("t2_enb_n1", o_wr_enb_rom, 1);
        check("t2_data_n1", o_wr_data, 16'h1122);
        i_rx_data = 8'h08;
        @(negedge i_clock);
        check("t2_enb_n2", o_wr_enb_rom, 0);
        i_rx_data = 8'h09;
        @(negedge i_clock);
        i_rx_valid = 1'b0;
        send_byte(8'h00);
        send_byte(8'h00);
        finish_load();
        wait_done(20, dc);
        check_cap("t2_w1", 1, 11'h001, 16'h0809);
        check("t2_count", o_word_count, 3);

        // Fill every address with non-HALT words; the last address ends the load.
        start_load();
        for (int i = 0; i < 2048; i++) add_word(8'h08, i[7:0]);
        plan_load();
        send_stim();
        finish_load();
        wait_done(20, dc);
        send_byte(8'h08);
        send_byte(8'h00);
        idle(3);
        check("t3_count", o_word_count, 2048);
        check("t3_writes", cap_addr.size(), 2048);
        check_cap("t3_last", 2047, 11'h7FF, 16'h08FF);
        check("t3_done_held", o_done, 1);

        // Restart drops a partial high byte.
        start_load();
        send_byte(8'h08);
        idle(2);
        start_load();
        add_word(8'h00, 8'h00);
        plan_load();
        send_stim();
        finish_load();
        wait_done(20, dc);
        check("t4_writes", cap_addr.size(), 1);
        check_cap("t4_w0", 0, 11'h000, 16'h0000);

        // Synchronous reset while waiting for a low byte.
        start_load();
        add_word(8'h08, 8'h05);
        plan_load();
        send_stim();
        idle(2);
        send_byte(8'h10);
        idle(1);
        check("t5_pending", exp_addr.size(), 0);
        check("t5_count_before", o_word_count, 1);
        i_reset = 1'b1;
        clear_model();
        @(negedge i_clock);
        check_reset_values("t5_rst");
        i_reset = 1'b0;
        add_word(8'h00, 8'h00);
        plan_load();
        send_stim();
        finish_load();
        wait_done(20, dc);
        check_cap("t5_w0", 0, 11'h000, 16'h0000);

`ifdef LOADER_CHECKSUM_EN
        // Correct checksum releases the CPU; a wrong one flags an error and holds it.
        start_load();
        add_word(8'h08, 8'h05);
        add_word(8'h00, 8'h00);
        plan_load();
        send_stim();
        idle(2);
        send_byte(8'h0D);
        idle(2);
        check("t6_ok_done", o_done, 1);
        check("t6_ok_error", o_error, 0);
        check("t6_ok_cpu", o_cpu_reset, 0);
        start_load();
        add_word(8'h08, 8'h05);
        add_word(8'h00, 8'h00);
        plan_load();
        send_stim();
        idle(2);
        send_byte(8'h0C);
        idle(2);
        check("t6_bad_done", o_done, 1);
        check("t6_bad_error", o_error, 1);
        check("t6_bad_cpu", o_cpu_reset, 1);
        send_byte(8'h0D);
        idle(2);
        check("t6_error_sticky", o_error, 1);
`endif

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
